// File: rtl/mips_pipeline_core.sv
// Five-stage MIPS-subset integer core (IF/ID/EX/MEM/WB) with forwarding or interlock,
// load-use stall, branch/jump flush and a data-memory wait handshake.
module mips_pipeline_core #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter bit              FWD_EN   = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic            dmem_we,
  output logic            dmem_re,
  input  logic [XLEN-1:0] dmem_rdata,
  input  logic            dmem_ready,
  output logic            wb_valid,
  output logic [4:0]      wb_reg,
  output logic [XLEN-1:0] wb_data
);

  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} aluOp_e;

  typedef struct packed {
    logic       regWrite;
    logic       memRead;
    logic       memWrite;
    logic       branch;
    logic       useImm;
    aluOp_e     aluOp;
    logic [4:0] dest;
  } ctrl_t;

  localparam logic [XLEN-1:0] LOW_MASK = XLEN'(32'h0FFF_FFFF);

  logic [XLEN-1:0] r_pc;
  logic            r_ifidValid;
  logic [31:0]     r_ifidInstr;
  logic [XLEN-1:0] r_ifidPc;

  logic            r_idexValid;
  ctrl_t           r_idexCtrl;
  logic [XLEN-1:0] r_idexPc, r_idexRsVal, r_idexRtVal, r_idexImm;
  logic [4:0]      r_idexRs, r_idexRt;

  logic            r_exmemValid, r_exmemRegWrite, r_exmemMemRead, r_exmemMemWrite;
  logic [4:0]      r_exmemDest;
  logic [XLEN-1:0] r_exmemAlu, r_exmemStore;

  logic            r_memwbValid, r_memwbRegWrite;
  logic [4:0]      r_memwbDest;
  logic [XLEN-1:0] r_memwbData;

  logic [XLEN-1:0] r_regs [32];

  logic [5:0]      w_op, w_funct;
  logic [4:0]      w_rs, w_rt, w_rd, w_shamt;
  logic [XLEN-1:0] w_immExt, w_ifidPcPlus4, w_jumpTarget;
  logic            w_rValid, w_useRs, w_useRt, w_isJump;
  ctrl_t           w_dec;
  logic [XLEN-1:0] w_rsVal, w_rtVal;
  logic            w_wbWrite, w_loadUse, w_exHit, w_memHit, w_stallId;
  logic [XLEN-1:0] w_rsFwd, w_rtFwd, w_aluB, w_aluOut, w_branchTarget;
  logic            w_branchTaken;

  assign w_op          = r_ifidInstr[31:26];
  assign w_rs          = r_ifidInstr[25:21];
  assign w_rt          = r_ifidInstr[20:16];
  assign w_rd          = r_ifidInstr[15:11];
  assign w_shamt       = r_ifidInstr[10:6];
  assign w_funct       = r_ifidInstr[5:0];
  assign w_immExt      = {{(XLEN-16){r_ifidInstr[15]}}, r_ifidInstr[15:0]};
  assign w_ifidPcPlus4 = r_ifidPc + XLEN'(4);
  assign w_jumpTarget  = (w_ifidPcPlus4 & ~LOW_MASK) | XLEN'({r_ifidInstr[25:0], 2'b00});
  // R-type ops are only recognised with a zero shift field; anything else is a NOP
  assign w_rValid      = (w_shamt == 5'd0) && (w_funct inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A});

  always_comb begin
    w_dec    = '0;
    w_useRs  = 1'b0;
    w_useRt  = 1'b0;
    w_isJump = 1'b0;
    case (w_op)
      6'h00: if (w_rValid) begin
        w_dec.regWrite = 1'b1;
        w_dec.dest     = w_rd;
        w_useRs        = 1'b1;
        w_useRt        = 1'b1;
        case (w_funct)
          6'h22:   w_dec.aluOp = ALU_SUB;
          6'h24:   w_dec.aluOp = ALU_AND;
          6'h25:   w_dec.aluOp = ALU_OR;
          6'h2A:   w_dec.aluOp = ALU_SLT;
          default: w_dec.aluOp = ALU_ADD;
        endcase
      end
      6'h08, 6'h23: begin
        w_dec.regWrite = 1'b1;
        w_dec.memRead  = (w_op == 6'h23);
        w_dec.useImm   = 1'b1;
        w_dec.dest     = w_rt;
        w_useRs        = 1'b1;
      end
      6'h2B: begin
        w_dec.memWrite = 1'b1;
        w_dec.useImm   = 1'b1;
        w_useRs        = 1'b1;
        w_useRt        = 1'b1;
      end
      6'h04: begin
        w_dec.branch = 1'b1;
        w_dec.aluOp  = ALU_SUB;
        w_useRs      = 1'b1;
        w_useRt      = 1'b1;
      end
      6'h02: w_isJump = 1'b1;
      default: ;
    endcase
    // Writes to r0 are dropped here so hazard and forwarding logic never sees r0
    if (w_dec.dest == 5'd0) w_dec.regWrite = 1'b0;
    if (!r_ifidValid) begin
      w_dec    = '0;
      w_useRs  = 1'b0;
      w_useRt  = 1'b0;
      w_isJump = 1'b0;
    end
  end

  assign w_wbWrite = r_memwbValid && r_memwbRegWrite && dmem_ready;
  assign w_rsVal   = (w_wbWrite && r_memwbDest == w_rs) ? r_memwbData : r_regs[w_rs];
  assign w_rtVal   = (w_wbWrite && r_memwbDest == w_rt) ? r_memwbData : r_regs[w_rt];

  assign w_loadUse = r_idexValid && r_idexCtrl.memRead && r_idexCtrl.regWrite &&
                     ((w_useRs && r_idexCtrl.dest == w_rs) || (w_useRt && r_idexCtrl.dest == w_rt));
  assign w_exHit   = r_idexValid && r_idexCtrl.regWrite &&
                     ((w_useRs && r_idexCtrl.dest == w_rs) || (w_useRt && r_idexCtrl.dest == w_rt));
  assign w_memHit  = r_exmemValid && r_exmemRegWrite &&
                     ((w_useRs && r_exmemDest == w_rs) || (w_useRt && r_exmemDest == w_rt));
  assign w_stallId = FWD_EN ? w_loadUse : (w_exHit || w_memHit);

  always_comb begin
    w_rsFwd = r_idexRsVal;
    w_rtFwd = r_idexRtVal;
    if (FWD_EN) begin
      if (r_exmemValid && r_exmemRegWrite && r_exmemDest == r_idexRs)      w_rsFwd = r_exmemAlu;
      else if (r_memwbValid && r_memwbRegWrite && r_memwbDest == r_idexRs) w_rsFwd = r_memwbData;
      if (r_exmemValid && r_exmemRegWrite && r_exmemDest == r_idexRt)      w_rtFwd = r_exmemAlu;
      else if (r_memwbValid && r_memwbRegWrite && r_memwbDest == r_idexRt) w_rtFwd = r_memwbData;
    end
  end

  assign w_aluB = r_idexCtrl.useImm ? r_idexImm : w_rtFwd;

  always_comb begin
    w_aluOut = w_rsFwd + w_aluB;
    case (r_idexCtrl.aluOp)
      ALU_SUB: w_aluOut = w_rsFwd - w_aluB;
      ALU_AND: w_aluOut = w_rsFwd & w_aluB;
      ALU_OR:  w_aluOut = w_rsFwd | w_aluB;
      ALU_SLT: w_aluOut = {{(XLEN-1){1'b0}}, ($signed(w_rsFwd) < $signed(w_aluB))};
      default: ;
    endcase
  end

  assign w_branchTaken  = r_idexValid && r_idexCtrl.branch && (w_rsFwd == w_rtFwd);
  assign w_branchTarget = r_idexPc + XLEN'(4) + (r_idexImm << 2);

  // A memory wait freezes everything; a taken beq outranks the ID stall and any j in ID
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pc         <= RESET_PC;
      r_ifidValid  <= 1'b0;
      r_idexValid  <= 1'b0;
      r_exmemValid <= 1'b0;
      r_memwbValid <= 1'b0;
      r_memwbDest  <= 5'd0;
      r_memwbData  <= '0;
    end else if (dmem_ready) begin
      r_memwbValid    <= r_exmemValid;
      r_memwbRegWrite <= r_exmemRegWrite;
      r_memwbDest     <= r_exmemDest;
      r_memwbData     <= r_exmemMemRead ? dmem_rdata : r_exmemAlu;

      r_exmemValid    <= r_idexValid;
      r_exmemRegWrite <= r_idexCtrl.regWrite;
      r_exmemMemRead  <= r_idexCtrl.memRead;
      r_exmemMemWrite <= r_idexCtrl.memWrite;
      r_exmemDest     <= r_idexCtrl.dest;
      r_exmemAlu      <= w_aluOut;
      r_exmemStore    <= w_rtFwd;

      if (w_branchTaken) begin
        r_pc        <= w_branchTarget;
        r_ifidValid <= 1'b0;
        r_idexValid <= 1'b0;
      end else if (w_stallId) begin
        r_idexValid <= 1'b0;
      end else begin
        r_idexValid <= r_ifidValid;
        r_idexCtrl  <= w_dec;
        r_idexPc    <= r_ifidPc;
        r_idexRsVal <= w_rsVal;
        r_idexRtVal <= w_rtVal;
        r_idexImm   <= w_immExt;
        r_idexRs    <= w_rs;
        r_idexRt    <= w_rt;
        if (w_isJump) begin
          r_pc        <= w_jumpTarget;
          r_ifidValid <= 1'b0;
        end else begin
          r_pc        <= r_pc + XLEN'(4);
          r_ifidValid <= 1'b1;
          r_ifidInstr <= imem_rdata;
          r_ifidPc    <= r_pc;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) r_regs[i] <= '0;
    end else if (w_wbWrite) begin
      r_regs[r_memwbDest] <= r_memwbData;
    end
  end

  assign imem_addr  = r_pc;
  assign dmem_addr  = r_exmemAlu;
  assign dmem_wdata = r_exmemStore;
  assign dmem_we    = reset && r_exmemValid && r_exmemMemWrite;
  assign dmem_re    = reset && r_exmemValid && r_exmemMemRead;
  assign wb_valid   = w_wbWrite;
  assign wb_reg     = r_memwbDest;
  assign wb_data    = r_memwbData;

endmodule
